// File: rtl/rcs_pkg.sv
// Shared types and helpers for the ripple counter sampler.
// Holds the tracking FSM state type and the modular delta used between qualified values.
package rcs_pkg;

    typedef enum logic {
        RCS_INIT,
        RCS_TRACK
    } rcs_state_t;

    // Difference new_v - old_v folded into a width-bit modular result.
    function automatic logic [31:0] mod_delta(
        input logic [31:0] new_v,
        input logic [31:0] old_v,
        input int unsigned width
    );
        logic [31:0] mask;
        mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return (new_v - old_v) & mask;
    endfunction

endpackage

// File: rtl/sync_2ff_bus.sv
// Per-bit two-flop synchronizer for a bus arriving from an unrelated clock domain.
// Bits are synchronized independently, so a multi-bit change may land skewed.
module sync_2ff_bus #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ripple_count_sampler.sv
// Samples a free-running ripple counter into the clk domain, filters ripple transients,
// and emits one valid/ready record (value, delta, wrap, epoch) per qualified count change.
module ripple_count_sampler
    import rcs_pkg::*;
#(
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned STABLE_CYCLES = 2,
    parameter int unsigned MAX_STEP      = 1,
    parameter int unsigned EPOCH_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   cnt_in,
    input  logic               clr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_count,
    output logic [WIDTH-1:0]   out_delta,
    output logic               out_wrap,
    output logic [EPOCH_W-1:0] out_epoch,
    output logic               err_skip,
    output logic               err_ovr
);

    localparam int unsigned RUN_W = $clog2(STABLE_CYCLES + 1);

    logic [WIDTH-1:0]   sync_q;
    logic [1:0]         prime_q;
    logic [WIDTH-1:0]   cand_q;
    logic [RUN_W-1:0]   run_q;
    logic               qual_pulse;
    logic [WIDTH-1:0]   qual_val;
    logic [WIDTH-1:0]   last_q;
    logic [EPOCH_W-1:0] epoch_q;
    rcs_state_t         state_q;
    rcs_state_t         state_next;

    logic [31:0]        delta_full;
    logic [WIDTH-1:0]   delta;
    logic               wrap;
    logic               skip;
    logic [EPOCH_W-1:0] epoch_inc;
    logic               seed;
    logic               rec_event;
    logic               load;

    sync_2ff_bus #(.WIDTH(WIDTH)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (cnt_in),
        .q   (sync_q)
    );

    // The synchronizer shows its reset zeros for two edges after release; those must
    // not qualify as a real count, so the filter waits until real data has arrived.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prime_q <= '0;
        end else begin
            prime_q <= {prime_q[0], 1'b1};
        end
    end

    // A run of identical samples qualifies exactly once, on its STABLE_CYCLES-th edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand_q     <= '0;
            run_q      <= '0;
            qual_pulse <= 1'b0;
            qual_val   <= '0;
        end else begin
            qual_pulse <= 1'b0;
            if (prime_q[1]) begin
                if ((sync_q == cand_q) && (run_q != '0)) begin
                    if (run_q == RUN_W'(STABLE_CYCLES - 1)) begin
                        qual_pulse <= 1'b1;
                        qual_val   <= sync_q;
                    end
                    if (run_q != RUN_W'(STABLE_CYCLES)) begin
                        run_q <= run_q + RUN_W'(1);
                    end
                end else begin
                    cand_q <= sync_q;
                    run_q  <= RUN_W'(1);
                    if (STABLE_CYCLES == 1) begin
                        qual_pulse <= 1'b1;
                        qual_val   <= sync_q;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RCS_INIT;
        end else begin
            state_q <= state_next;
        end
    end

    // clr wins over a simultaneous qualify: that value is simply lost and the next one seeds.
    always_comb begin
        state_next = state_q;
        delta_full = mod_delta(32'(qual_val), 32'(last_q), WIDTH);
        delta      = delta_full[WIDTH-1:0];
        wrap       = (qual_val < last_q);
        skip       = (delta_full > MAX_STEP);
        epoch_inc  = epoch_q + EPOCH_W'(wrap);
        seed       = 1'b0;
        rec_event  = 1'b0;
        load       = 1'b0;
        if (clr) begin
            state_next = RCS_INIT;
        end else if (qual_pulse) begin
            if (state_q == RCS_INIT) begin
                seed       = 1'b1;
                state_next = RCS_TRACK;
            end else if (qual_val != last_q) begin
                rec_event = 1'b1;
                load      = !out_valid || out_ready;
            end
        end
    end

    // Tracking state advances even when the slot is full, so later deltas stay exact.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q    <= '0;
            epoch_q   <= '0;
            err_skip  <= 1'b0;
            err_ovr   <= 1'b0;
            out_valid <= 1'b0;
            out_count <= '0;
            out_delta <= '0;
            out_wrap  <= 1'b0;
            out_epoch <= '0;
        end else if (clr) begin
            epoch_q   <= '0;
            err_skip  <= 1'b0;
            err_ovr   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (seed) begin
                last_q <= qual_val;
            end
            if (rec_event) begin
                last_q  <= qual_val;
                epoch_q <= epoch_inc;
                if (skip) begin
                    err_skip <= 1'b1;
                end
                if (!load) begin
                    err_ovr <= 1'b1;
                end
            end
            if (load) begin
                out_valid <= 1'b1;
                out_count <= qual_val;
                out_delta <= delta;
                out_wrap  <= wrap;
                out_epoch <= epoch_inc;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ripple_count_sampler.sv
// Self-checking bench for ripple_count_sampler: directed vectors, corner sequences and a
// randomized run checked against an arithmetic model of the record stream.
module tb_ripple_count_sampler;

    localparam int W  = 4;
    localparam int EW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr;
    logic [W-1:0]  cnt_in;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_count;
    logic [W-1:0]  out_delta;
    logic          out_wrap;
    logic [EW-1:0] out_epoch;
    logic          err_skip;
    logic          err_ovr;

    int checks_total  = 0;
    int checks_passed = 0;

    typedef struct packed {
        logic [W-1:0]  count;
        logic [W-1:0]  delta;
        logic          wrap;
        logic [EW-1:0] epoch;
    } rec_t;

    typedef struct {
        bit           clr_first;
        logic [W-1:0] val;
        int           hold;
        int           exp_rec;
        rec_t         rec;
    } vec_t;

    rec_t exp_q[$];
    bit   use_queue = 1'b0;
    int   rec_count = 0;
    rec_t last_rec;
    rec_t mon_exp;
    vec_t tbl[8];

    int   m_last;
    int   m_epoch;
    bit   m_seeded;
    bit   m_skip;

    always #5 clk = ~clk;

    ripple_count_sampler #(
        .WIDTH(W), .STABLE_CYCLES(2), .MAX_STEP(1), .EPOCH_W(EW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cnt_in    (cnt_in),
        .clr       (clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .out_delta (out_delta),
        .out_wrap  (out_wrap),
        .out_epoch (out_epoch),
        .err_skip  (err_skip),
        .err_ovr   (err_ovr)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // rmode 0/1: fixed ready; rmode 2: random ready, forced high for the last 3 cycles.
    task automatic applyStimulus(input logic [W-1:0] v, input int cycles, input int rmode);
        cnt_in = v;
        for (int i = 0; i < cycles; i++) begin
            if (rmode == 2) begin
                out_ready = (i >= cycles - 3) ? 1'b1 : 1'($urandom_range(0, 1));
            end else begin
                out_ready = (rmode == 1);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulseClr();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    // Reference: a held value qualifies; records follow plain modular arithmetic.
    task automatic modelQualify(input int v);
        rec_t r;
        if (!m_seeded) begin
            m_seeded = 1'b1;
            m_last   = v;
        end else if (v != m_last) begin
            r.count = W'(v);
            r.delta = W'((v - m_last + 16) % 16);
            r.wrap  = (v < m_last);
            m_epoch = (m_epoch + ((v < m_last) ? 1 : 0)) % 256;
            r.epoch = EW'(m_epoch);
            if (((v - m_last + 16) % 16) > 1) m_skip = 1'b1;
            exp_q.push_back(r);
            m_last = v;
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            rec_count++;
            last_rec = '{out_count, out_delta, out_wrap, out_epoch};
            if (use_queue) begin
                checkOutput("rand_record_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    mon_exp = exp_q.pop_front();
                    checkOutput("rand_record", 32'(last_rec), 32'(mon_exp));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int rc0;
        int v;
        int r;

        tbl[0] = '{1'b1, 4'd13, 6, 0, '{4'd0,  4'd0, 1'b0, 8'd0}};
        tbl[1] = '{1'b0, 4'd14, 6, 1, '{4'd14, 4'd1, 1'b0, 8'd0}};
        tbl[2] = '{1'b0, 4'd15, 6, 1, '{4'd15, 4'd1, 1'b0, 8'd0}};
        tbl[3] = '{1'b0, 4'd0,  6, 1, '{4'd0,  4'd1, 1'b1, 8'd1}};
        tbl[4] = '{1'b0, 4'd1,  6, 1, '{4'd1,  4'd1, 1'b0, 8'd1}};
        tbl[5] = '{1'b1, 4'd7,  6, 0, '{4'd0,  4'd0, 1'b0, 8'd0}};
        tbl[6] = '{1'b0, 4'd4,  1, 0, '{4'd0,  4'd0, 1'b0, 8'd0}};
        tbl[7] = '{1'b0, 4'd8,  6, 1, '{4'd8,  4'd1, 1'b0, 8'd0}};

        rst = 1'b1; clr = 1'b0; cnt_in = 4'd3; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_fields", {out_count, out_delta, out_wrap, out_epoch}, 32'd0);
        checkOutput("reset_flags", {err_skip, err_ovr}, 32'd0);
        rst = 1'b0;

        $display("[TB] seed and first-record latency");
        applyStimulus(4'd3, 8, 1);
        checkOutput("seed_no_record", 32'(rec_count), 32'd0);
        checkOutput("seed_no_valid", 32'(out_valid), 32'd0);
        cnt_in = 4'd4;
        for (int e = 0; e <= 4; e++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("latency_edge%0d", e), 32'(out_valid), (e == 4) ? 32'd1 : 32'd0);
        end
        applyStimulus(4'd4, 2, 1);
        checkOutput("first_record", 32'(last_rec), 32'({4'd4, 4'd1, 1'b0, 8'd0}));

        $display("[TB] vector table: wrap steps and glitch");
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].clr_first) pulseClr();
            rc0 = rec_count;
            applyStimulus(tbl[i].val, tbl[i].hold, 1);
            checkOutput($sformatf("tbl%0d_nrec", i), 32'(rec_count - rc0), 32'(tbl[i].exp_rec));
            if (tbl[i].exp_rec != 0)
                checkOutput($sformatf("tbl%0d_rec", i), 32'(last_rec), 32'(tbl[i].rec));
        end
        checkOutput("glitch_no_skip", 32'(err_skip), 32'd0);

        $display("[TB] back-pressure overflow");
        pulseClr();
        applyStimulus(4'd4, 8, 1);
        applyStimulus(4'd5, 6, 0);
        applyStimulus(4'd6, 6, 0);
        applyStimulus(4'd7, 6, 0);
        checkOutput("ovr_held_valid", 32'(out_valid), 32'd1);
        checkOutput("ovr_held_fields", {out_count, out_delta}, 32'h51);
        checkOutput("ovr_flag", 32'(err_ovr), 32'd1);
        rc0 = rec_count;
        applyStimulus(4'd8, 6, 1);
        checkOutput("ovr_drain_nrec", 32'(rec_count - rc0), 32'd2);
        checkOutput("ovr_after", 32'(last_rec), 32'({4'd8, 4'd1, 1'b0, 8'd0}));
        checkOutput("ovr_no_skip", 32'(err_skip), 32'd0);

        $display("[TB] skip flag and clr");
        pulseClr();
        applyStimulus(4'd2, 8, 1);
        applyStimulus(4'd6, 6, 1);
        checkOutput("skip_rec", 32'(last_rec), 32'({4'd6, 4'd4, 1'b0, 8'd0}));
        checkOutput("skip_flag", 32'(err_skip), 32'd1);
        applyStimulus(4'd7, 6, 1);
        checkOutput("skip_sticky", 32'(err_skip), 32'd1);
        applyStimulus(4'd0, 6, 1);
        checkOutput("skip_wrap_rec", 32'(last_rec), 32'({4'd0, 4'd9, 1'b1, 8'd1}));
        pulseClr();
        checkOutput("clr_flags", {err_skip, err_ovr, out_valid}, 32'd0);
        rc0 = rec_count;
        applyStimulus(4'd15, 8, 1);
        checkOutput("clr_reseed", 32'(rec_count - rc0), 32'd0);
        applyStimulus(4'd0, 6, 1);
        checkOutput("clr_epoch", 32'(last_rec), 32'({4'd0, 4'd1, 1'b1, 8'd1}));

        $display("[TB] async reset mid-stream");
        applyStimulus(4'd1, 6, 0);
        checkOutput("pre_rst_valid", 32'(out_valid), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("async_rst_fields", {out_count, out_epoch, err_skip, err_ovr}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rc0 = rec_count;
        applyStimulus(4'd1, 8, 1);
        checkOutput("rst_reseed", 32'(rec_count - rc0), 32'd0);
        applyStimulus(4'd2, 6, 1);
        checkOutput("rst_after", 32'(last_rec), 32'({4'd2, 4'd1, 1'b0, 8'd0}));

        $display("[TB] randomized stream");
        pulseClr();
        m_seeded = 1'b0; m_epoch = 0; m_skip = 1'b0; m_last = 0;
        use_queue = 1'b1;
        for (int n = 0; n < 60; n++) begin
            if (n > 0 && $urandom_range(0, 3) == 0)
                applyStimulus(W'($urandom_range(0, 15)), 1, 2);
            if (n == 0) begin
                v = 5;
            end else begin
                r = $urandom_range(0, 9);
                if (r < 6)      v = (m_last + 1) % 16;
                else if (r < 8) v = m_last;
                else            v = $urandom_range(0, 15);
            end
            modelQualify(v);
            applyStimulus(W'(v), $urandom_range(7, 10), 2);
        end
        out_ready = 1'b1;
        for (int t = 0; t < 20 && exp_q.size() > 0; t++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("rand_drained", 32'(exp_q.size()), 32'd0);
        checkOutput("rand_skip_flag", 32'(err_skip), 32'(m_skip));
        checkOutput("rand_no_ovr", 32'(err_ovr), 32'd0);
        use_queue = 1'b0;

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
